ysyx_25010008_alu_dispatch: RTL and testbench
=============================================

YSYX_25010008_ALU_DISPATCH -- requirements
Module: ysyx_25010008_alu_dispatch

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flush, input, 1, synchronous queue clear.
REQ-004 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-005 SHALL have port in_ready, output, 1, dispatcher can accept.
REQ-006 SHALL have port inst, input, 32, RV32I instruction word.
REQ-007 SHALL have port pc, input, 32, instruction address.
REQ-008 SHALL have port rs1_data, input, 32, register-file read value for rs1.
REQ-009 SHALL have port rs2_data, input, 32, register-file read value for rs2.
REQ-010 SHALL have port out_valid, output, 1, ALU request valid.
REQ-011 SHALL have port out_ready, input, 1, ALU stage accepts.
REQ-012 SHALL have port alu_opcode, output, 8, ALU operation code.
REQ-013 SHALL have port operand1, output, 32, ALU first operand.
REQ-014 SHALL have port operand2, output, 32, ALU second operand.
REQ-015 SHALL have port rd, output, 5, destination register.
REQ-016 SHALL have port rd_wen, output, 1, writeback enable.
REQ-017 SHALL have port is_branch, output, 1, result is a branch condition.
REQ-018 SHALL have port illegal, output, 1, instruction not decodable.
REQ-019 SHALL have port illegal_cnt, output, 8, saturating count of illegal instructions enqueued.

Function
REQ-020 SHALL enqueue decoded fields into a 2-entry FIFO when in_valid and in_ready are both 1; in_ready SHALL be 1 exactly when fewer than 2 entries are held.
REQ-021 SHALL assert out_valid when the FIFO is non-empty and drive the output fields from the head entry; the head SHALL pop when out_valid and out_ready are both 1.
REQ-022 SHALL give 1-cycle latency: an instruction accepted in cycle N SHALL appear at the outputs in cycle N+1 when the FIFO was empty.
REQ-023 SHALL hold output fields stable while out_valid=1 and out_ready=0.
REQ-024 SHALL allow push and pop in the same cycle when 1 entry is held; occupancy SHALL stay 1 and order SHALL be preserved.
REQ-025 SHALL decode opcode 0110011 (OP) as follows: ADD=0x00, SUB=0x01, XOR=0x02, OR=0x04, AND=0x08, SLL=0x10, SRL=0x20, SRA=0x40, SLT=0x21, SLTU=0x09; operand1=rs1_data, operand2=rs2_data, rd_wen=1.
REQ-026 SHALL decode opcode 0010011 (OP-IMM) with the same codes; operand2 SHALL be the sign-extended I-immediate, or zero-extended shamt inst[24:20] for shifts.
REQ-027 SHALL decode LUI as 0x00 with operand1=0 and operand2={inst[31:12],12'b0}, and AUIPC as 0x00 with operand1=pc and the same operand2; both SHALL set rd_wen=1.
REQ-028 SHALL decode BRANCH (1100011) as follows: BEQ=0x03, BNE=0x05, BLT=0x21, BGE=0x41, BLTU=0x09, BGEU=0x11; operands SHALL be rs1_data and rs2_data, with is_branch=1 and rd_wen=0.
REQ-029 SHALL force rd_wen=0 whenever rd=0.
REQ-030 SHALL mark as illegal any other opcode, funct3 010/011 under BRANCH, or a funct7 other than 0000000, or other than 0100000 for SUB/SRA/SRAI; illegal entries SHALL still enqueue with illegal=1, alu_opcode=0x00, rd_wen=0, and is_branch=0.
REQ-031 SHALL increment illegal_cnt on each illegal push, saturating at 255.
REQ-032 SHALL empty the FIFO when flush=1, dropping any same-cycle push, and leave illegal_cnt unchanged.

Reset
REQ-033 SHALL, while rst_n=0, clear the FIFO and force out_valid=0, in_ready=0, alu_opcode=0, operand1=0, operand2=0, rd=0, rd_wen=0, is_branch=0, illegal=0, and illegal_cnt=0, immediately and independent of clock.
REQ-034 SHALL raise in_ready in the first cycle after rst_n deasserts; reset mid-transfer SHALL discard all held entries.

Verification
REQ-035 SHALL pass this scenario: push SUB x3,x1,x2 (0x402081B3) with rs1_data=10, rs2_data=3, out_ready=1 -> next cycle alu_opcode=0x01, operand1=10, operand2=3, rd=3, rd_wen=1.
REQ-036 SHALL pass this scenario: push ADDI x5,x0,-1 (0xFFF00293) -> alu_opcode=0x00, operand2=0xFFFFFFFF; push BGEU (funct3=111) -> alu_opcode=0x11, is_branch=1, rd_wen=0.
REQ-037 SHALL pass this scenario: out_ready=0 with 3 back-to-back pushes -> in_ready falls after 2 accepts, third held upstream; releasing out_ready drains entries in order.
REQ-038 SHALL pass this scenario: 1 entry held, push and pop in the same cycle -> occupancy stays 1, and the next head is the newly pushed instruction.
REQ-039 SHALL pass this scenario: 300 illegal words (0xFFFFFFFF) -> each exits with illegal=1, and illegal_cnt saturates at 255; flush with 2 entries held -> out_valid=0 in the next cycle.
REQ-040 SHALL pass this scenario: rst_n pulsed low mid-stream with 2 entries held -> outputs zero asynchronously, and all entries are lost.

Source files
------------

// File: rtl/ysyx_25010008_alu_dispatch.sv
// RV32I ALU dispatcher: decodes OP/OP-IMM/LUI/AUIPC/BRANCH into ALU requests
// and buffers them in a 2-entry FIFO whose head drives the outputs.
module ysyx_25010008_alu_dispatch (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  alu_opcode,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [4:0]  rd,
  output logic        rd_wen,
  output logic        is_branch,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        br;
    logic        ill;
  } entry_t;

  entry_t      r_slot0, r_slot1, w_dec;
  logic [1:0]  r_cnt;
  logic        r_live;
  logic [7:0]  r_ill_cnt;
  logic        w_legal, w_is_op, w_shift, w_push, w_pop;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;

  assign w_f3    = inst[14:12];
  assign w_f7    = inst[31:25];
  assign w_is_op = (inst[6:0] == 7'b0110011);
  assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  always_comb begin
    w_dec    = '0;
    w_legal  = 1'b1;
    w_dec.rd = inst[11:7];
    case (inst[6:0])
      7'b0110011, 7'b0010011: begin
        w_dec.wen = 1'b1;
        w_dec.a   = rs1_data;
        if (w_is_op)      w_dec.b = rs2_data;
        else if (w_shift) w_dec.b = {27'b0, inst[24:20]};
        else              w_dec.b = {{20{inst[31]}}, inst[31:20]};
        case (w_f3)
          3'b000: begin
            w_dec.op = (w_is_op && w_f7 == 7'b0100000) ? 8'h01 : 8'h00;
            w_legal  = !w_is_op || w_f7 == 7'b0000000 || w_f7 == 7'b0100000;
          end
          3'b001: begin
            w_dec.op = 8'h10;
            w_legal  = (w_f7 == 7'b0000000);
          end
          3'b101: begin
            w_dec.op = (w_f7 == 7'b0100000) ? 8'h40 : 8'h20;
            w_legal  = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          3'b010: begin w_dec.op = 8'h21; w_legal = !w_is_op || w_f7 == 7'b0; end
          3'b011: begin w_dec.op = 8'h09; w_legal = !w_is_op || w_f7 == 7'b0; end
          3'b100: begin w_dec.op = 8'h02; w_legal = !w_is_op || w_f7 == 7'b0; end
          3'b110: begin w_dec.op = 8'h04; w_legal = !w_is_op || w_f7 == 7'b0; end
          default: begin w_dec.op = 8'h08; w_legal = !w_is_op || w_f7 == 7'b0; end
        endcase
      end
      7'b0110111: begin
        w_dec.wen = 1'b1;
        w_dec.b   = {inst[31:12], 12'b0};
      end
      7'b0010111: begin
        w_dec.wen = 1'b1;
        w_dec.a   = pc;
        w_dec.b   = {inst[31:12], 12'b0};
      end
      7'b1100011: begin
        w_dec.br = 1'b1;
        w_dec.a  = rs1_data;
        w_dec.b  = rs2_data;
        case (w_f3)
          3'b000:  w_dec.op = 8'h03;
          3'b001:  w_dec.op = 8'h05;
          3'b100:  w_dec.op = 8'h21;
          3'b101:  w_dec.op = 8'h41;
          3'b110:  w_dec.op = 8'h09;
          3'b111:  w_dec.op = 8'h11;
          default: w_legal  = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec.op  = 8'h00;
      w_dec.a   = '0;
      w_dec.b   = '0;
      w_dec.wen = 1'b0;
      w_dec.br  = 1'b0;
      w_dec.ill = 1'b1;
    end
    if (w_dec.rd == 5'd0) w_dec.wen = 1'b0;
  end

  // r_live holds in_ready low until the first edge after reset release
  assign in_ready  = r_live && (r_cnt != 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_cnt     <= '0;
      r_slot0   <= '0;
      r_slot1   <= '0;
      r_ill_cnt <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push && w_dec.ill && r_ill_cnt != '1) r_ill_cnt <= r_ill_cnt + 8'd1;
      if (flush) begin
        r_cnt <= '0;
      end else begin
        // head always lives in r_slot0; simultaneous push/pop only occurs at occupancy 1
        case ({w_push, w_pop})
          2'b10: begin
            if (r_cnt == 2'd0) r_slot0 <= w_dec;
            else               r_slot1 <= w_dec;
            r_cnt <= r_cnt + 2'd1;
          end
          2'b01: begin
            r_slot0 <= r_slot1;
            r_cnt   <= r_cnt - 2'd1;
          end
          2'b11:   r_slot0 <= w_dec;
          default: ;
        endcase
      end
    end
  end

  assign alu_opcode  = r_slot0.op;
  assign operand1    = r_slot0.a;
  assign operand2    = r_slot0.b;
  assign rd          = r_slot0.rd;
  assign rd_wen      = r_slot0.wen;
  assign is_branch   = r_slot0.br;
  assign illegal     = r_slot0.ill;
  assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_ysyx_25010008_alu_dispatch.sv
// Directed bench for the ALU dispatcher: decode table, backpressure,
// push/pop overlap, flush, illegal-count saturation and async reset.
module tb_ysyx_25010008_alu_dispatch;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  alu_opcode;
  logic [31:0] operand1, operand2;
  logic [4:0]  rd;
  logic        rd_wen, is_branch, illegal;
  logic [7:0]  illegal_cnt;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned exp_cnt = 0;

  ysyx_25010008_alu_dispatch dut (
    .clock(clock), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .inst(inst), .pc(pc), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_opcode(alu_opcode), .operand1(operand1), .operand2(operand2),
    .rd(rd), .rd_wen(rd_wen), .is_branch(is_branch), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
    inst = i; pc = p; rs1_data = a; rs2_data = b;
  endtask

  task automatic push_chk(input string tag, input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] e_op, input logic [31:0] e1, input logic [31:0] e2,
                          input logic [4:0] e_rd, input logic e_wen, input logic e_br,
                          input logic e_ill);
    out_ready = 1'b1;
    set_in(i, p, a, b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (e_ill && exp_cnt < 255) exp_cnt++;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"}, 32'(alu_opcode), 32'(e_op));
    chk({tag, ".wen"}, 32'(rd_wen), 32'(e_wen));
    chk({tag, ".br"}, 32'(is_branch), 32'(e_br));
    chk({tag, ".ill"}, 32'(illegal), 32'(e_ill));
    chk({tag, ".icnt"}, 32'(illegal_cnt), exp_cnt);
    if (!e_ill) begin
      chk({tag, ".op1"}, operand1, e1);
      chk({tag, ".op2"}, operand2, e2);
      chk({tag, ".rd"}, 32'(rd), 32'(e_rd));
    end
    tick();
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd0);
    chk("rst.op1", operand1, 32'd0);
    chk("rst.icnt", 32'(illegal_cnt), 32'd0);
    tick(); tick();
    chk("rst.ready_clk", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst.ready", 32'(in_ready), 32'd1);
    chk("post_rst.valid", 32'(out_valid), 32'd0);

    push_chk("sub",   32'h402081B3, 0, 10, 3, 8'h01, 10, 3, 5'd3, 1, 0, 0);
    push_chk("addi",  32'hFFF00293, 0, 0, 32'h55, 8'h00, 0, 32'hFFFFFFFF, 5'd5, 1, 0, 0);
    push_chk("bgeu",  32'h0020F063, 0, 32'h80000000, 1, 8'h11, 32'h80000000, 1, 5'd0, 0, 1, 0);
    push_chk("srai",  32'h4030D213, 0, 32'hF0, 7, 8'h40, 32'hF0, 3, 5'd4, 1, 0, 0);
    push_chk("slli",  32'h01F09913, 0, 1, 7, 8'h10, 1, 31, 5'd18, 1, 0, 0);
    push_chk("andi",  32'h7FF0F593, 0, 9, 7, 8'h08, 9, 32'h7FF, 5'd11, 1, 0, 0);
    push_chk("xori",  32'h8000C613, 0, 9, 7, 8'h02, 9, 32'hFFFFF800, 5'd12, 1, 0, 0);
    push_chk("slt",   32'h0020A333, 0, 5, 6, 8'h21, 5, 6, 5'd6, 1, 0, 0);
    push_chk("sltu",  32'h0020B3B3, 0, 5, 6, 8'h09, 5, 6, 5'd7, 1, 0, 0);
    push_chk("sra",   32'h4020D433, 0, 5, 6, 8'h40, 5, 6, 5'd8, 1, 0, 0);
    push_chk("srl",   32'h0020D6B3, 0, 5, 6, 8'h20, 5, 6, 5'd13, 1, 0, 0);
    push_chk("sll",   32'h00209733, 0, 5, 6, 8'h10, 5, 6, 5'd14, 1, 0, 0);
    push_chk("or",    32'h0020E7B3, 0, 5, 6, 8'h04, 5, 6, 5'd15, 1, 0, 0);
    push_chk("xor",   32'h0020C833, 0, 5, 6, 8'h02, 5, 6, 5'd16, 1, 0, 0);
    push_chk("and",   32'h0020F8B3, 0, 5, 6, 8'h08, 5, 6, 5'd17, 1, 0, 0);
    push_chk("add_x0", 32'h00208033, 0, 5, 6, 8'h00, 5, 6, 5'd0, 0, 0, 0);
    push_chk("lui",   32'h123454B7, 0, 32'hDEAD, 6, 8'h00, 0, 32'h12345000, 5'd9, 1, 0, 0);
    push_chk("auipc", 32'h12345517, 32'h80000010, 32'hDEAD, 6, 8'h00, 32'h80000010, 32'h12345000, 5'd10, 1, 0, 0);
    push_chk("beq",   32'h00208063, 0, 5, 6, 8'h03, 5, 6, 5'd0, 0, 1, 0);
    push_chk("bne",   32'h00209063, 0, 5, 6, 8'h05, 5, 6, 5'd0, 0, 1, 0);
    push_chk("blt",   32'h0020C063, 0, 5, 6, 8'h21, 5, 6, 5'd0, 0, 1, 0);
    push_chk("bge",   32'h0020D063, 0, 5, 6, 8'h41, 5, 6, 5'd0, 0, 1, 0);
    push_chk("bltu",  32'h0020E063, 0, 5, 6, 8'h09, 5, 6, 5'd0, 0, 1, 0);
    push_chk("ill_slli", 32'h40309213, 0, 5, 6, 8'h00, 0, 0, 5'd0, 0, 0, 1);
    push_chk("ill_br010", 32'h0020A063, 0, 5, 6, 8'h00, 0, 0, 5'd0, 0, 0, 1);
    push_chk("ill_br011", 32'h0020B063, 0, 5, 6, 8'h00, 0, 0, 5'd0, 0, 0, 1);
    push_chk("ill_xorf7", 32'h0220C0B3, 0, 5, 6, 8'h00, 0, 0, 5'd0, 0, 0, 1);
    push_chk("ill_sllf7", 32'h40209733, 0, 5, 6, 8'h00, 0, 0, 5'd0, 0, 0, 1);
    push_chk("ill_ones", 32'hFFFFFFFF, 0, 5, 6, 8'h00, 0, 0, 5'd0, 0, 0, 1);

    // backpressure: A and B accepted, C held upstream, then ordered drain
    out_ready = 1'b0;
    set_in(32'h00208033 | (32'd1 << 7), 0, 32'h111, 0);
    in_valid = 1'b1;
    tick();
    chk("bp.ready1", 32'(in_ready), 32'd1);
    set_in(32'h00208033 | (32'd1 << 7), 0, 32'h222, 0);
    tick();
    chk("bp.ready2", 32'(in_ready), 32'd0);
    set_in(32'h00208033 | (32'd1 << 7), 0, 32'h333, 0);
    tick();
    chk("bp.ready3", 32'(in_ready), 32'd0);
    chk("bp.headA", operand1, 32'h111);
    tick();
    chk("bp.stableA", operand1, 32'h111);
    chk("bp.stable_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp.headB", operand1, 32'h222);
    chk("bp.ready_after_pop", 32'(in_ready), 32'd1);
    tick();
    chk("pp.headC", operand1, 32'h333);
    chk("pp.valid", 32'(out_valid), 32'd1);
    chk("pp.ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // flush with two entries held
    out_ready = 1'b0;
    set_in(32'h00208033 | (32'd1 << 7), 0, 32'h444, 0);
    in_valid = 1'b1;
    tick(); tick();
    chk("fl2.full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2.valid", 32'(out_valid), 32'd0);
    chk("fl2.ready", 32'(in_ready), 32'd1);
    // flush drops a same-cycle illegal push without counting it
    in_valid = 1'b1;
    tick();
    set_in(32'hFFFFFFFF, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl1.valid", 32'(out_valid), 32'd0);
    chk("fl1.icnt", 32'(illegal_cnt), exp_cnt);

    // 300 illegal words streamed with push and pop every cycle
    out_ready = 1'b1;
    set_in(32'hFFFFFFFF, 0, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_cnt < 255) exp_cnt++;
      chk("ill300.valid", 32'(out_valid), 32'd1);
      chk("ill300.ill", 32'(illegal), 32'd1);
      chk("ill300.op", 32'(alu_opcode), 32'd0);
      chk("ill300.icnt", 32'(illegal_cnt), exp_cnt);
    end
    in_valid = 1'b0;
    tick();
    chk("ill300.sat", 32'(illegal_cnt), 32'd255);
    chk("ill300.empty", 32'(out_valid), 32'd0);

    // async reset with two entries held
    out_ready = 1'b0;
    set_in(32'h00208033 | (32'd1 << 7), 0, 32'h5A5A, 32'h77);
    in_valid = 1'b1;
    tick();
    set_in(32'hFFFFFFFF, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("ar.pre_valid", 32'(out_valid), 32'd1);
    chk("ar.pre_op1", operand1, 32'h5A5A);
    #1 rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(out_valid), 32'd0);
    chk("ar.ready", 32'(in_ready), 32'd0);
    chk("ar.op1", operand1, 32'd0);
    chk("ar.op2", operand2, 32'd0);
    chk("ar.rd", 32'(rd), 32'd0);
    chk("ar.wen", 32'(rd_wen), 32'd0);
    chk("ar.icnt", 32'(illegal_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    chk("ar.post_ready", 32'(in_ready), 32'd1);
    chk("ar.post_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("ar.lost", 32'(out_valid), 32'd0);
    push_chk("ar.sub", 32'h402081B3, 0, 10, 3, 8'h01, 10, 3, 5'd3, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
